alu_ctrl_md: RTL

Parametrised successor to the single-cycle ALU control decoder. It keeps the existing ALUControl encoding for base RV32I operations and adds RV32M multiply/divide support through an iterative shift-add/restoring sequencer. It sits between the main decoder and the datapath. For RV32M operations it stalls the single-cycle core with a start/stall/done handshake until the result is ready.

---
 rtl/alu_ctrl_md.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_md.sv
// rtl/alu_ctrl_md.sv - ALU control decoder with iterative RV32M multiply/divide sequencer
module alu_ctrl_md #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_i,
   input  logic [2:0]      ALUOp,
   input  logic [2:0]      funct3,
   input  logic            funct7b5,
   input  logic            op_r,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic [3:0]      ALUControl,
   output logic            stall,
   output logic            md_done,
   output logic [XLEN-1:0] md_result
);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opa_q, opa_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [XLEN-1:0]   rs1_q, rs1_d;
   logic [XLEN-1:0]   md_result_q, md_result_d;
   logic [2:0]        f3_q, f3_d;
   logic              a_neg_q, a_neg_d;
   logic              b_neg_q, b_neg_d;
   logic              b_zero_q, b_zero_d;

   logic              md_req, last_step;
   logic              sign_a, sign_b, a_neg, b_neg;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [XLEN:0]     mul_sum, div_shl, div_diff;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

   assign md_req    = valid_i & (ALUOp == 3'b101);
   assign last_step = (cnt_q == CNT_W'(XLEN - 1));

   // Multiplies: mul/mulh sign both, mulhsu only A. Divides: div/rem signed, *u unsigned.
   assign sign_a = funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]);
   assign sign_b = funct3[2] ? ~funct3[0] : ~funct3[1];
   assign a_neg  = sign_a & rs1[XLEN-1];
   assign b_neg  = sign_b & rs2[XLEN-1];
   assign a_abs  = a_neg ? (~rs1 + XLEN'(1)) : rs1;
   assign b_abs  = b_neg ? (~rs2 + XLEN'(1)) : rs2;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q & {XLEN{opa_q[0]}}};
   assign div_shl  = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
   assign div_diff = div_shl - {1'b0, opb_q};
   assign div_ge   = ~div_diff[XLEN];
   assign div_rem  = div_ge ? div_diff[XLEN-1:0] : div_shl[XLEN-1:0];

   // Signed overflow (MIN / -1) falls out of the magnitude datapath: |q| = MIN, negation keeps MIN.
   assign prod_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + (2*XLEN)'(1)) : acc_q;
   assign quot_fix = (a_neg_q ^ b_neg_q) ? (~opa_q + XLEN'(1)) : opa_q;
   assign rem_fix  = a_neg_q ? (~acc_q[2*XLEN-1:XLEN] + XLEN'(1)) : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      fix_result = '0;
      case (f3_q)
         3'b000:                 fix_result = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_result = b_zero_q ? {XLEN{1'b1}} : quot_fix;
         default:                fix_result = b_zero_q ? rs1_q : rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         rs1_q       <= '0;
         md_result_q <= '0;
         f3_q        <= '0;
         a_neg_q     <= 1'b0;
         b_neg_q     <= 1'b0;
         b_zero_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         rs1_q       <= rs1_d;
         md_result_q <= md_result_d;
         f3_q        <= f3_d;
         a_neg_q     <= a_neg_d;
         b_neg_q     <= b_neg_d;
         b_zero_q    <= b_zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (md_req) state_d = funct3[2] ? S_DIV : S_MUL;
         S_MUL:   if (last_step) state_d = S_FIX;
         S_DIV:   if (last_step) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      rs1_d       = rs1_q;
      md_result_d = md_result_q;
      f3_d        = f3_q;
      a_neg_d     = a_neg_q;
      b_neg_d     = b_neg_q;
      b_zero_d    = b_zero_q;
      case (state_q)
         S_IDLE: if (md_req) begin
            cnt_d    = '0;
            acc_d    = '0;
            opa_d    = a_abs;
            opb_d    = b_abs;
            rs1_d    = rs1;
            f3_d     = funct3;
            a_neg_d  = a_neg;
            b_neg_d  = b_neg;
            b_zero_d = (rs2 == '0);
         end
         S_MUL: begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
            opa_d = opa_q >> 1;
         end
         S_DIV: begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = {div_rem, acc_q[XLEN-1:0]};
            opa_d = {opa_q[XLEN-2:0], div_ge};
         end
         S_FIX: begin
            cnt_d       = '0;
            md_result_d = fix_result;
         end
         default: ;
      endcase
   end

   always_comb begin
      ALUControl = 4'b0000;
      if (ALUOp == 3'b000) begin
         case (funct3)
            3'b000:  ALUControl = (op_r & funct7b5) ? 4'b0001 : 4'b0000;
            3'b001:  ALUControl = 4'b0100;
            3'b010:  ALUControl = 4'b0101;
            3'b011:  ALUControl = 4'b1000;
            3'b100:  ALUControl = 4'b0110;
            3'b101:  ALUControl = funct7b5 ? 4'b1111 : 4'b0111;
            3'b110:  ALUControl = 4'b0011;
            default: ALUControl = 4'b0010;
         endcase
      end else if (ALUOp == 3'b011) begin
         ALUControl = 4'b0001;
      end else if (ALUOp == 3'b100) begin
         ALUControl = 4'b1001;
      end
      stall     = (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX)
                | ((state_q == S_IDLE) & md_req);
      md_done   = (state_q == S_DONE);
      md_result = md_result_q;
   end

endmodule
